// File: rtl/ms_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ms_mult_pkg                                                     |
// | Purpose  : Shared types and helpers for the radix-4 Booth multiplier.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ms_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    B_ZERO = 3'd0,
    B_P1   = 3'd1,
    B_P2   = 3'd2,
    B_M1   = 3'd3,
    B_M2   = 3'd4
  } booth_sel_t;

  // One guard bit so unsigned operands stay positive, rounded up to even for radix-4.
  function automatic int calc_ew(input int dw);
    return dw + 1 + ((dw + 1) % 2);
  endfunction

endpackage : ms_mult_pkg
`default_nettype wire

// File: rtl/ms_booth_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ms_booth_enc                                                    |
// | Purpose  : Radix-4 Booth recoder, 3-bit multiplier window to term select.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ms_booth_enc
  import ms_mult_pkg::*;
(
  input  logic [2:0] i_win,
  output booth_sel_t o_sel
);

  always_comb begin
    o_sel = B_ZERO;
    case (i_win)
      3'b001, 3'b010: o_sel = B_P1;
      3'b011:         o_sel = B_P2;
      3'b100:         o_sel = B_M2;
      3'b101, 3'b110: o_sel = B_M1;
      default:        o_sel = B_ZERO;
    endcase
  end

endmodule : ms_booth_enc
`default_nettype wire

// File: rtl/ms_booth_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ms_booth_mult                                                   |
// | Purpose  : Sequential signed/unsigned radix-4 Booth multiplier with a      |
// |            start/ready/done handshake. Optional sign-magnitude output in   |
// |            signed mode when MS_MULT_SIGNMAG_EN is defined.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ms_booth_mult
  import ms_mult_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [DW-1:0]   i_multd,
  input  logic [DW-1:0]   i_multr,
  output logic [2*DW-1:0] o_product,
  output logic            o_ready,
  output logic            o_done
);

  localparam int EW    = calc_ew(DW);
  localparam int NITER = EW / 2;
  localparam int AW    = 2 * EW + 1;
  localparam int XW    = EW - DW;
  localparam int CW    = $clog2(NITER + 1);

  state_t            state_q;
  logic              start_q;
  logic              signed_q;
  logic [DW-1:0]     multd_q;
  logic [DW-1:0]     multr_q;
  logic [EW-1:0]     mcand_q;
  logic [AW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic [2*DW-1:0]   product_q;
  logic              ready_q;
  logic              done_q;

  logic              w_edge;
  booth_sel_t        w_sel;
  logic [EW+1:0]     w_mext;
  logic [EW+1:0]     w_term;
  logic [EW+1:0]     w_hi;
  logic [EW+1:0]     w_sum;
  logic [AW+1:0]     w_wide;
  logic [AW-1:0]     acc_d;
  logic [2*EW-1:0]   w_prod_full;
  logic [2*DW-1:0]   product_d;
  logic              w_unused;

  function automatic logic [EW-1:0] extend(input logic [DW-1:0] x, input logic s);
    return {{XW{s & x[DW-1]}}, x};
  endfunction

  assign w_edge = i_start & ~start_q;

  ms_booth_enc u_enc (
    .i_win (acc_q[2:0]),
    .o_sel (w_sel)
  );

  // Upper part is widened by two bits so +/-2M never overflows before the shift.
  assign w_mext = {{2{mcand_q[EW-1]}}, mcand_q};
  assign w_hi   = {{2{acc_q[AW-1]}}, acc_q[AW-1:EW+1]};

  always_comb begin
    w_term = '0;
    case (w_sel)
      B_P1:    w_term = w_mext;
      B_P2:    w_term = {w_mext[EW:0], 1'b0};
      B_M1:    w_term = -w_mext;
      B_M2:    w_term = -{w_mext[EW:0], 1'b0};
      default: w_term = '0;
    endcase
  end

  assign w_sum  = w_hi + w_term;
  assign w_wide = {w_sum, acc_q[EW:0]};
  assign acc_d  = w_wide[AW+1:2];

  assign w_prod_full = acc_q[AW-1:1];

`ifdef MS_MULT_SIGNMAG_EN
  logic              w_neg;
  logic [2*EW-1:0]   w_mag;
  logic              w_unused_mag;

  assign w_neg        = signed_q & w_prod_full[2*EW-1];
  assign w_mag        = w_neg ? -w_prod_full : w_prod_full;
  assign product_d    = {w_neg, w_mag[2*DW-2:0]};
  assign w_unused_mag = ^w_mag;
`else
  assign product_d = w_prod_full[2*DW-1:0];
`endif

  assign w_unused = ^{acc_q[0], w_prod_full};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      signed_q  <= 1'b0;
      multd_q   <= '0;
      multr_q   <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      start_q <= i_start;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (w_edge) begin
            signed_q <= i_signed;
            multd_q  <= i_multd;
            multr_q  <= i_multr;
            ready_q  <= 1'b0;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          mcand_q <= extend(multd_q, signed_q);
          acc_q   <= {{EW{1'b0}}, extend(multr_q, signed_q), 1'b0};
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NITER - 1)) begin
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          product_q <= product_d;
          done_q    <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_product = product_q;
  assign o_ready   = ready_q;
  assign o_done    = done_q;

endmodule : ms_booth_mult
`default_nettype wire
